// File: rtl/prom_pkg.sv
// prom_pkg: shared widths, response codes and FSM states for the PROM programmer
package prom_pkg;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam logic [1:0] RESP_OK     = 2'b00;
    localparam logic [1:0] RESP_VFAIL  = 2'b01;
    localparam logic [1:0] RESP_BURNED = 2'b10;
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, VERIFY, RESP} state_t;
endpackage

// File: rtl/prom_pulse_timer.sv
// prom_pulse_timer: 4-bit load/decrement counter with zero flag for phase durations
module prom_pulse_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic       i_dec,
    input  logic [3:0] i_val,
    output logic       o_zero
);
    logic [3:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (i_dec && !o_zero)
            r_cnt <= r_cnt - 4'd1;
    end
    assign o_zero = (r_cnt == 4'd0);
endmodule

// File: rtl/prom_programmer.sv
// prom_programmer: one-time PROM burner with program pulse, read-back verify and burned map
module prom_programmer
    import prom_pkg::*;
#(
    parameter int PULSE_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              prog_en,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              resp_valid,
    output logic [1:0]        resp_code,
    output logic [15:0]       burned,
    output logic              all_burned
);
    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr, r_rd_addr;
    logic [DATA_W-1:0] r_data;
    logic [15:0]       r_burned;
    logic [1:0]        r_code;
    logic              r_wait;
    logic              w_accept, w_zero, w_load, w_dec;
    logic [3:0]        w_load_val;

    prom_pulse_timer u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_dec  (w_dec),
        .i_val  (w_load_val),
        .o_zero (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next = r_burned[req_addr] ? RESP : SETUP;
            SETUP:   w_next = PULSE;
            PULSE:   if (w_zero) w_next = HOLD;
            HOLD:    w_next = VERIFY;
            VERIFY:  if (w_zero) w_next = RESP;
            RESP:    w_next = r_wait ? RESP : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == IDLE);
        prog_en    = (r_state == PULSE);
        resp_valid = (r_state == RESP) && !r_wait;
        resp_code  = resp_valid ? r_code : RESP_OK;
        w_load     = (r_state == SETUP) || (r_state == HOLD);
        w_dec      = (r_state == PULSE) || (r_state == VERIFY);
        w_load_val = (r_state == SETUP) ? 4'(PULSE_CYCLES - 1) : 4'(SETTLE_CYCLES - 1);
    end

    assign w_accept   = req_valid && req_ready;
    assign prog_addr  = r_addr;
    assign prog_data  = r_data;
    assign rd_addr    = r_rd_addr;
    assign burned     = r_burned;
    assign all_burned = &r_burned;

    // A rejected request spends one silent RESP cycle so its reply lands one edge after acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_data    <= '0;
            r_rd_addr <= '0;
            r_burned  <= '0;
            r_code    <= RESP_OK;
            r_wait    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= req_addr;
                r_data <= req_data;
                r_code <= RESP_BURNED;
                r_wait <= r_burned[req_addr];
            end
            if (r_state == RESP)
                r_wait <= 1'b0;
            if (r_state == PULSE && w_zero)
                r_burned[r_addr] <= 1'b1;
            if (r_state == HOLD)
                r_rd_addr <= r_addr;
            if (r_state == VERIFY && w_zero)
                r_code <= (rd_data == r_data) ? RESP_OK : RESP_VFAIL;
        end
    end
endmodule

// File: tb/tb_prom_programmer.sv
// tb_prom_programmer: randomized checks of the PROM programmer against a behavioural PROM and burn map
module tb_prom_programmer;
    localparam int P = 4;
    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_addr = '0;
    logic [7:0] req_data = '0;
    logic       prog_en;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic       resp_valid;
    logic [1:0] resp_code;
    logic [15:0] burned;
    logic       all_burned;

    logic [7:0] prom [16];
    logic [7:0] mmem [16];
    logic [15:0] mburn = '0;
    bit         force_rd = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    prom_programmer #(.PULSE_CYCLES(P), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .prog_en(prog_en),
        .prog_addr(prog_addr), .prog_data(prog_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .resp_valid(resp_valid), .resp_code(resp_code),
        .burned(burned), .all_burned(all_burned)
    );

    always #5 clk = ~clk;

    always @(posedge prog_en) prom[prog_addr] <= prog_data;
    assign rd_data = force_rd ? 8'h00 : prom[rd_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [3:0] a, input logic [7:0] d, input bit f0, input bit hold,
                       input logic [3:0] a2, input logic [7:0] d2, output int waited);
        int lat, pe;
        bit got;
        logic [1:0] ec;
        int el;
        ec = mburn[a] ? 2'b10 : (f0 && d != 8'h00) ? 2'b01 : 2'b00;
        el = mburn[a] ? 1 : 2 + P + S;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        check("ready_wait", waited < 50, 1);
        force_rd = f0;
        @(posedge clk);
        #1;
        if (hold) begin
            req_addr = a2;
            req_data = d2;
        end else
            req_valid = 1'b0;
        lat = 0;
        pe  = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            pe += int'(prog_en);
            got = resp_valid;
            if (!got) check("busy_ready", req_ready, 0);
        end
        force_rd = 1'b0;
        check("latency", lat, el);
        check("resp_code", resp_code, ec);
        check("pulse_width", pe, mburn[a] ? 0 : P);
        if (!mburn[a]) mmem[a] = d;
        mburn[a] = 1'b1;
        check("burned", burned, mburn);
        check("prom_content", prom[a], mmem[a]);
    endtask

    initial begin
        int w, cnt;
        logic [3:0] a;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) begin
            prom[i] = 8'h00;
            mmem[i] = 8'h00;
        end
        #12;
        check("rst_prog_en", prog_en, 0);
        check("rst_prog_addr", prog_addr, 0);
        check("rst_prog_data", prog_data, 0);
        check("rst_rd_addr", rd_addr, 0);
        check("rst_resp", {resp_valid, resp_code}, 0);
        check("rst_burned", {all_burned, burned}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", req_ready, 1);

        run(4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, w);
        check("burned_0008", burned, 16'h0008);
        run(4'd3, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00, w);
        check("prom3_kept", prom[3], 8'hA5);
        run(4'd5, 8'hFF, 1'b1, 1'b0, 4'd0, 8'h00, w);
        check("burned5", burned[5], 1);

        d = 8'($urandom);
        run(4'd7, 8'($urandom), 1'b0, 1'b1, 4'd9, d, w);
        run(4'd9, d, 1'b0, 1'b0, 4'd0, 8'h00, w);
        check("held_wait", w, 1);
        check("held_data", prom[9], d);

        repeat (8) run(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(0, 3) == 0, 1'b0, 4'd0, 8'h00, w);

        a = 4'd0;
        for (int i = 15; i >= 0; i--) if (!mburn[i]) a = 4'(i);
        d = 8'($urandom);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        cnt = 0;
        while (!req_ready && cnt < 50) begin
            cnt++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid_pulse_en", prog_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_en", prog_en, 0);
        check("rst_clr_burned", {all_burned, burned}, 0);
        check("rst_no_resp", resp_valid, 0);
        mmem[a] = d;
        mburn   = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rel", req_ready, 1);
        cnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            cnt += int'(resp_valid);
        end
        check("no_resp_after_rst", cnt, 0);

        for (int i = 0; i < 16; i++) run(4'(i), ~{4'h0, 4'(i)}, 1'b0, 1'b0, 4'd0, 8'h00, w);
        check("all_ffff", burned, 16'hFFFF);
        check("all_burned", all_burned, 1);
        run(4'($urandom_range(0, 15)), 8'($urandom), 1'b0, 1'b0, 4'd0, 8'h00, w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
